pdm_mixer: RTL and testbench

Multi-channel mixing pulse-density DAC for the sound peripheral output pin. It sums CHANNELS unsigned channel levels, gated per channel by an enable mask, and drives one output bit. The output comes from either a first-order or a second-order sigma-delta modulator, and the modulator is clocked by a programmable prescaler. Channel levels, mask and mode are double-buffered behind a load strobe, so the sound core can update them at any time without glitching the bitstream.

---
 rtl/pdm_mixer_if.sv | 17 +
 rtl/pdm_mixer.sv | 104 ++++++++++
 tb/tb_pdm_mixer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pdm_mixer_if.sv
// Sound-core side of the PDM mixer: channel levels, load strobe, prescale and the bitstream back.
interface pdm_mixer_if #(
    parameter int VALUE_BITS    = 8,
    parameter int CHANNELS      = 3,
    parameter int PRESCALE_BITS = 4
);
    logic [CHANNELS*VALUE_BITS-1:0] value;
    logic [CHANNELS-1:0]            mask;
    logic                           mode;
    logic                           load;
    logic [PRESCALE_BITS-1:0]       prescale;
    logic                           out;
    logic                           tick;

    modport master (output value, mask, mode, load, prescale, input out, tick);
    modport slave  (input value, mask, mode, load, prescale, output out, tick);
endinterface

// File: rtl/pdm_mixer.sv
// Multi-channel mixing sigma-delta DAC (1st/2nd order) with double-buffered settings.
// Latency: load -> shadow at k, sum_r at k+1, first use on a tick at k+2 or later; no backpressure.
module pdm_mixer #(
    parameter int VALUE_BITS    = 8,
    parameter int CHANNELS      = 3,
    parameter int PRESCALE_BITS = 4
) (
    input logic       clk,
    input logic       reset,
    pdm_mixer_if.slave bus
);
    localparam int SUM_BITS = (CHANNELS > 1) ? VALUE_BITS + $clog2(CHANNELS) : VALUE_BITS;
    localparam int IW = SUM_BITS + 4;
    localparam int XW = SUM_BITS + 6;
    localparam logic signed [XW-1:0] SAT_HI = XW'((64'sd1 <<< (SUM_BITS + 2)) - 64'sd1);
    localparam logic signed [XW-1:0] SAT_LO = ~SAT_HI;

    logic [CHANNELS*VALUE_BITS-1:0] value_s;
    logic [CHANNELS-1:0]            mask_s;
    logic                           mode_s;
    logic [SUM_BITS-1:0]            sum_r;
    logic [SUM_BITS-1:0]            sum_c;
    logic [PRESCALE_BITS-1:0]       cnt;
    logic                           tick_c;
    logic [SUM_BITS:0]              acc;
    logic [SUM_BITS:0]              acc_n;
    logic signed [IW-1:0]           i1;
    logic signed [IW-1:0]           i2;
    logic signed [IW-1:0]           i1n;
    logic signed [IW-1:0]           i2n;
    logic signed [XW-1:0]           f_x;
    logic signed [XW-1:0]           i1_x;
    logic signed [XW-1:0]           i2_x;
    logic                           out_r;
    logic                           mode_chg;

    function automatic logic signed [IW-1:0] sat(input logic signed [XW-1:0] x);
        if (x > SAT_HI) return SAT_HI[IW-1:0];
        if (x < SAT_LO) return SAT_LO[IW-1:0];
        return x[IW-1:0];
    endfunction

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (mask_s[i]) sum_c = sum_c + SUM_BITS'(value_s[i*VALUE_BITS +: VALUE_BITS]);
        end
    end

    // A prescale lowered below cnt must still terminate the period, hence >=.
    assign tick_c   = !reset && (cnt >= bus.prescale);
    assign mode_chg = bus.load && (bus.mode != mode_s);

    always_comb begin
        acc_n = {1'b0, acc[SUM_BITS-1:0]} + {1'b0, sum_r};
        f_x   = '0;
        if (out_r) f_x[SUM_BITS] = 1'b1;
        i1_x  = XW'(i1) + XW'($signed({1'b0, sum_r})) - f_x;
        i1n   = sat(i1_x);
        i2_x  = XW'(i2) + XW'(i1n) - f_x;
        i2n   = sat(i2_x);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_s <= '0;
            mask_s  <= '0;
            mode_s  <= 1'b0;
            sum_r   <= '0;
            cnt     <= '0;
            acc     <= '0;
            i1      <= '0;
            i2      <= '0;
            out_r   <= 1'b0;
        end else begin
            sum_r <= sum_c;
            cnt   <= tick_c ? '0 : cnt + PRESCALE_BITS'(1);
            if (bus.load) begin
                value_s <= bus.value;
                mask_s  <= bus.mask;
                mode_s  <= bus.mode;
            end
            // A mode change restarts both modulators from zero, overriding any tick.
            if (mode_chg) begin
                acc   <= '0;
                i1    <= '0;
                i2    <= '0;
                out_r <= 1'b0;
            end else if (tick_c) begin
                if (!mode_s) begin
                    acc   <= acc_n;
                    out_r <= acc_n[SUM_BITS];
                end else begin
                    i1    <= i1n;
                    i2    <= i2n;
                    out_r <= !i2n[IW-1] && (i2n != '0);
                end
            end
        end
    end

    assign bus.out  = out_r;
    assign bus.tick = tick_c;
endmodule

// File: tb/tb_pdm_mixer.sv
// Randomized and directed bench for pdm_mixer against an arithmetic reference model.
module tb_pdm_mixer;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    bit   chk_en;

    pdm_mixer_if #(.VALUE_BITS(8), .CHANNELS(3), .PRESCALE_BITS(4)) bus();
    pdm_mixer #(.VALUE_BITS(8), .CHANNELS(3), .PRESCALE_BITS(4)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase arithmetic for 1st order, clamped integer recurrences for 2nd order.
    int m_val[3];
    int m_mask, m_mode, m_sum, m_cnt, m_out, m_phase, m_i1, m_i2;

    function automatic int clamp(input int x);
        if (x > 4095) return 4095;
        if (x < -4096) return -4096;
        return x;
    endfunction

    always @(posedge clk) begin
        int nsum, fb;
        bit t;
        if (reset) begin
            for (int c = 0; c < 3; c++) m_val[c] = 0;
            m_mask = 0; m_mode = 0; m_sum = 0; m_cnt = 0;
            m_out = 0; m_phase = 0; m_i1 = 0; m_i2 = 0;
        end else begin
            t = (m_cnt >= int'(bus.prescale));
            nsum = 0;
            for (int c = 0; c < 3; c++) if (m_mask[c]) nsum += m_val[c];
            if (t) begin
                if (m_mode == 0) begin
                    m_phase = m_phase + m_sum;
                    m_out   = (m_phase >= 1024) ? 1 : 0;
                    m_phase = m_phase % 1024;
                end else begin
                    fb    = m_out ? 1024 : 0;
                    m_i1  = clamp(m_i1 + m_sum - fb);
                    m_i2  = clamp(m_i2 + m_i1 - fb);
                    m_out = (m_i2 > 0) ? 1 : 0;
                end
            end
            if (bus.load) begin
                if (int'(bus.mode) != m_mode) begin
                    m_phase = 0; m_i1 = 0; m_i2 = 0; m_out = 0;
                end
                for (int c = 0; c < 3; c++) m_val[c] = int'(bus.value[c*8 +: 8]);
                m_mask = int'(bus.mask);
                m_mode = int'(bus.mode);
            end
            m_sum = nsum;
            m_cnt = t ? 0 : m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tick_vs_model", bus.tick, (!reset && m_cnt >= int'(bus.prescale)) ? 1 : 0);
            chk("out_vs_model", bus.out, m_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [23:0] v, input logic [2:0] mk, input logic md,
                           input logic [3:0] ps);
        step();
        bus.value = v; bus.mask = mk; bus.mode = md; bus.prescale = ps; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    // Counts ones over n modulator updates; out is read at the negedge after each tick cycle.
    task automatic count_ticks(input int n, input int gap, input bit rng, output int ones);
        int done, cyc, last, v1, v2;
        bit pending;
        ones = 0; done = 0; cyc = 0; last = -1; pending = 0;
        while (done < n && cyc < n * 20 + 100) begin
            @(negedge clk);
            cyc++;
            if (pending) begin
                ones += int'(bus.out);
                done++;
            end
            pending = bus.tick;
            if (bus.tick) begin
                if (gap > 0 && last >= 0) chk("tick_gap", cyc - last, gap);
                last = cyc;
                if (rng) begin
                    v1 = int'(dut.i1);
                    v2 = int'(dut.i2);
                    chk("i1_in_range", (v1 >= -4096 && v1 <= 4095) ? 1 : 0, 1);
                    chk("i2_in_range", (v2 >= -4096 && v2 <= 4095) ? 1 : 0, 1);
                end
            end
        end
        if (done < n) chk("tick_budget", done, n);
    endtask

    initial begin
        int ones, idx, first;
        total = 0; bad = 0; chk_en = 0;
        reset = 1'b1;
        bus.value = '0; bus.mask = '0; bus.mode = 1'b0; bus.load = 1'b0; bus.prescale = '0;
        step(); step();
        chk_en = 1;
        @(negedge clk);
        chk("rst_out", bus.out, 0);
        chk("rst_tick", bus.tick, 0);
        chk("rst_cnt", dut.cnt, 0);
        chk("rst_sum", dut.sum_r, 0);
        chk("rst_acc", dut.acc, 0);
        chk("rst_i1", dut.i1, 0);
        chk("rst_i2", dut.i2, 0);
        step();
        reset = 1'b0;

        // Zero input: silent stream, tick every cycle.
        do_load(24'h000000, 3'b111, 1'b0, 4'd0);
        count_ticks(2048, 1, 0, ones);
        chk("zero_ones", ones, 0);

        // Full scale on all three channels.
        do_load({8'd255, 8'd255, 8'd255}, 3'b111, 1'b0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        chk("sum_765", dut.sum_r, 765);
        count_ticks(1024, 1, 0, ones);
        chk("ones_765", ones, 765);

        // Only channel 1, slower prescale.
        do_load({8'd255, 8'd128, 8'd255}, 3'b010, 1'b0, 4'd3);
        @(negedge clk);
        @(negedge clk);
        chk("sum_128", dut.sum_r, 128);
        count_ticks(1024, 4, 0, ones);
        chk("ones_128", ones, 128);

        // Second order at half scale.
        do_load({8'd2, 8'd255, 8'd255}, 3'b111, 1'b1, 4'd0);
        count_ticks(64, 1, 1, ones);
        count_ticks(1024, 1, 1, ones);
        chk("ones_512_pm2", (ones >= 510 && ones <= 514) ? 1 : 0, 1);

        // Second order from a cleared state with zero input.
        do_load(24'h0, 3'b111, 1'b0, 4'd0);
        do_load(24'h0, 3'b111, 1'b1, 4'd0);
        count_ticks(512, 1, 1, ones);
        chk("o2_zero_ones", ones, 0);

        // Mode switch while out=1 clears everything.
        do_load({8'd2, 8'd255, 8'd255}, 3'b111, 1'b1, 4'd7);
        idx = 0;
        while (idx < 400 && !(bus.out && !bus.tick)) begin
            step();
            idx++;
        end
        chk("saw_out_high", bus.out, 1);
        bus.mode = 1'b0; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        chk("sw_out", bus.out, 0);
        chk("sw_acc", dut.acc, 0);
        chk("sw_i1", dut.i1, 0);
        chk("sw_i2", dut.i2, 0);

        // Reset mid-stream in second order, with loads offered during reset.
        do_load({8'd100, 8'd200, 8'd50}, 3'b111, 1'b1, 4'd5);
        repeat (200) step();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out", bus.out, 0);
        bus.value = 24'hABCDEF; bus.mask = 3'b101; bus.mode = 1'b0; bus.load = 1'b1;
        step(); step();
        reset = 1'b0; bus.load = 1'b0;
        @(negedge clk);
        chk("midrst_value_s", dut.value_s, 0);
        chk("midrst_mask_s", dut.mask_s, 0);
        chk("midrst_mode_s", dut.mode_s, 0);
        first = -1;
        for (int i = 0; i < 20 && first < 0; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.tick) first = i + 1;
        end
        chk("first_tick_after_rst", first, 6);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step();
            idx = $urandom_range(0, 99);
            bus.load = 1'b0;
            reset = 1'b0;
            if (idx < 8) begin
                bus.value = 24'($urandom);
                bus.mask  = 3'($urandom);
                bus.mode  = 1'($urandom);
                bus.load  = 1'b1;
            end else if (idx == 8) begin
                bus.prescale = 4'($urandom_range(0, 4));
            end else if (idx == 9) begin
                reset = 1'b1;
            end
        end
        step();
        bus.load = 1'b0;
        reset = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
